// File: rtl/pipe_ctrl_pkg.sv
// Shared definitions for the pipeline sequencer: state encoding, default widths
// and the opcode values the hazard and redirect logic agree on.
package pipe_ctrl_pkg;

   localparam int PC_W_DEF  = 10;
   localparam int CNT_W_DEF = 16;

   typedef enum logic [2:0] {
      ST_PRIME  = 3'd0,
      ST_RUN    = 3'd1,
      ST_REFILL = 3'd2,
      ST_HALTED = 3'd3
   } state_e;

   // MIPS primary opcodes recognised by the stall and jump/branch detectors
   localparam logic [5:0] OP_RTYPE = 6'h00;
   localparam logic [5:0] OP_J     = 6'h02;
   localparam logic [5:0] OP_BEQ   = 6'h04;
   localparam logic [5:0] OP_LW    = 6'h23;
   localparam logic [5:0] OP_SW    = 6'h2b;
   localparam logic [5:0] OP_HALT  = 6'h3f;

   // Number of advance cycles the memory/wback stages keep running after halt
   localparam logic [1:0] DRAIN_CYCLES = 2'd2;

endpackage

// File: rtl/step_pulse.sv
// Synchronises the raw step key and emits a one-cycle pulse per rising edge.
// Flops reset to 1 so a key already held during reset is never seen as a press.
module step_pulse (
   input  logic clock,
   input  logic reset,
   input  logic key,
   output logic pulse
);

   logic [2:0] sync_q;
   logic [2:0] sync_d;

   always_comb begin
      sync_d = {sync_q[1:0], key};
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         sync_q <= 3'b111;
      end else begin
         sync_q <= sync_d;
      end
   end

   assign pulse = sync_q[1] & ~sync_q[2];

endmodule

// File: rtl/pipe_sequencer.sv
// Pipeline control: PC and PC shadows, per-stage load/flush strobes, redirect,
// load-use stall, halt drain and pause/single-step.
module pipe_sequencer
   import pipe_ctrl_pkg::*;
#(
   parameter int PC_W  = PC_W_DEF,
   parameter int CNT_W = CNT_W_DEF
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             run,
   input  logic             step,
   input  logic             stall_req,
   input  logic             jump_req,
   input  logic [PC_W-1:0]  jump_target,
   input  logic             beq_req,
   input  logic [PC_W-1:0]  beq_offset,
   input  logic             halt_req,
   output logic [PC_W-1:0]  pc,
   output logic [PC_W-1:0]  pc_decode,
   output logic [PC_W-1:0]  pc_execute,
   output logic             decode_load,
   output logic             decode_flush,
   output logic             exec_load,
   output logic             exec_flush,
   output logic             back_en,
   output logic [2:0]       state,
   output logic [CNT_W-1:0] cycle_count,
   output logic [7:0]       stall_count
);

   state_e           state_q, state_d;
   logic [PC_W-1:0]  pc_q, pc_d;
   logic [PC_W-1:0]  pcd_q, pcd_d;
   logic [PC_W-1:0]  pce_q, pce_d;
   logic [1:0]       drain_q, drain_d;
   logic [CNT_W-1:0] cyc_q, cyc_d;
   logic [7:0]       stl_q, stl_d;
   logic             step_edge;
   logic             advance;

   step_pulse u_step_pulse (
      .clock (clock),
      .reset (reset),
      .key   (step),
      .pulse (step_edge)
   );

   // Strobes must stay low while reset is held, even though PRIME would fire them
   assign advance = reset & (run | step_edge);

   always_comb begin
      state_d      = state_q;
      pc_d         = pc_q;
      pcd_d        = pcd_q;
      pce_d        = pce_q;
      drain_d      = drain_q;
      cyc_d        = cyc_q;
      stl_d        = stl_q;
      decode_load  = 1'b0;
      decode_flush = 1'b0;
      exec_load    = 1'b0;
      exec_flush   = 1'b0;
      back_en      = 1'b0;

      if (advance) begin
         unique case (state_q)
            ST_PRIME, ST_REFILL: begin
               pc_d         = pc_q + 1'b1;
               decode_flush = 1'b1;
               exec_flush   = 1'b1;
               back_en      = 1'b1;
               state_d      = ST_RUN;
            end
            ST_RUN: begin
               if (halt_req) begin
                  decode_flush = 1'b1;
                  exec_flush   = 1'b1;
                  back_en      = 1'b1;
                  drain_d      = DRAIN_CYCLES;
                  state_d      = ST_HALTED;
               end else if (jump_req || beq_req) begin
                  pc_d         = jump_req ? jump_target : pce_q + beq_offset;
                  decode_flush = 1'b1;
                  exec_flush   = 1'b1;
                  back_en      = 1'b1;
                  state_d      = ST_REFILL;
               end else if (stall_req) begin
                  exec_flush   = 1'b1;
                  back_en      = 1'b1;
                  if (stl_q != 8'hff) stl_d = stl_q + 8'd1;
               end else begin
                  pc_d         = pc_q + 1'b1;
                  pcd_d        = pc_q;
                  decode_load  = 1'b1;
                  exec_load    = 1'b1;
                  back_en      = 1'b1;
               end
            end
            ST_HALTED: begin
               if (drain_q != 2'd0) begin
                  back_en = 1'b1;
                  drain_d = drain_q - 2'd1;
               end
            end
            default: state_d = ST_PRIME;
         endcase

         if (back_en) pce_d = pcd_q;
         if (state_q != ST_HALTED && cyc_q != {CNT_W{1'b1}}) cyc_d = cyc_q + 1'b1;
      end
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state_q <= ST_PRIME;
         pc_q    <= '0;
         pcd_q   <= '0;
         pce_q   <= '0;
         drain_q <= 2'd0;
         cyc_q   <= '0;
         stl_q   <= 8'd0;
      end else begin
         state_q <= state_d;
         pc_q    <= pc_d;
         pcd_q   <= pcd_d;
         pce_q   <= pce_d;
         drain_q <= drain_d;
         cyc_q   <= cyc_d;
         stl_q   <= stl_d;
      end
   end

   assign pc          = pc_q;
   assign pc_decode   = pcd_q;
   assign pc_execute  = pce_q;
   assign state       = state_q;
   assign cycle_count = cyc_q;
   assign stall_count = stl_q;

endmodule

// File: tb/tb_pipe_sequencer.sv
// Directed plus randomized bench for pipe_sequencer against a cycle-level
// behavioural model of the pipeline control rules.
module tb_pipe_sequencer;

   logic        clock = 1'b0;
   logic        reset = 1'b0;
   logic        run = 1'b0;
   logic        step = 1'b0;
   logic        stall_req = 1'b0;
   logic        jump_req = 1'b0;
   logic [9:0]  jump_target = '0;
   logic        beq_req = 1'b0;
   logic [9:0]  beq_offset = '0;
   logic        halt_req = 1'b0;
   logic [9:0]  pc, pc_decode, pc_execute;
   logic        decode_load, decode_flush, exec_load, exec_flush, back_en;
   logic [2:0]  state;
   logic [15:0] cycle_count;
   logic [7:0]  stall_count;

   int checks = 0;
   int errors = 0;

   // behavioural model: architectural values plus raw key history
   int m_pc, m_pcd, m_pce, m_st, m_dr, m_cyc, m_stl;
   bit samp[$];
   logic last_be;

   pipe_sequencer dut (
      .clock(clock), .reset(reset), .run(run), .step(step),
      .stall_req(stall_req), .jump_req(jump_req), .jump_target(jump_target),
      .beq_req(beq_req), .beq_offset(beq_offset), .halt_req(halt_req),
      .pc(pc), .pc_decode(pc_decode), .pc_execute(pc_execute),
      .decode_load(decode_load), .decode_flush(decode_flush),
      .exec_load(exec_load), .exec_flush(exec_flush), .back_en(back_en),
      .state(state), .cycle_count(cycle_count), .stall_count(stall_count)
   );

   always #5 clock = ~clock;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
      checks++;
      assert (obs === exp_v) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp_v);
      end
   endtask

   task automatic model_clear();
      m_pc = 0; m_pcd = 0; m_pce = 0; m_st = 0; m_dr = 0; m_cyc = 0; m_stl = 0;
      samp.delete();
      repeat (3) samp.push_back(1'b1);
   endtask

   task automatic clear_reqs();
      stall_req = 0; jump_req = 0; beq_req = 0; halt_req = 0;
   endtask

   // Called at posedge+1; asserts reset part-way through the cycle.
   task automatic do_reset();
      #3;
      reset = 1'b0;
      #1;
      model_clear();
      chk("rst_pc", pc, 0);
      chk("rst_pcd", pc_decode, 0);
      chk("rst_pce", pc_execute, 0);
      chk("rst_state", state, 0);
      chk("rst_cyc", cycle_count, 0);
      chk("rst_stl", stall_count, 0);
      chk("rst_be", back_en, 0);
      chk("rst_df", decode_flush, 0);
      @(posedge clock);
      #1;
      reset = 1'b1;
   endtask

   // One clock: check outputs in the second half-cycle, then advance the model.
   task automatic tick();
      bit pulse, adv;
      bit e_dl, e_df, e_el, e_ef, e_be;
      int n_pc, n_pcd, n_pce, n_st, n_dr;
      @(negedge clock);
      #1;
      pulse = samp[samp.size()-2] && !samp[samp.size()-3];
      adv = run || pulse;
      e_dl = 0; e_df = 0; e_el = 0; e_ef = 0; e_be = 0;
      n_pc = m_pc; n_pcd = m_pcd; n_pce = m_pce; n_st = m_st; n_dr = m_dr;
      if (adv) begin
         if (m_st == 0 || m_st == 2) begin
            n_pc = (m_pc + 1) & 1023; e_df = 1; e_ef = 1; e_be = 1; n_st = 1;
         end else if (m_st == 1) begin
            if (halt_req) begin
               e_df = 1; e_ef = 1; e_be = 1; n_st = 3; n_dr = 2;
            end else if (jump_req) begin
               n_pc = jump_target; e_df = 1; e_ef = 1; e_be = 1; n_st = 2;
            end else if (beq_req) begin
               n_pc = (m_pce + beq_offset) & 1023; e_df = 1; e_ef = 1; e_be = 1; n_st = 2;
            end else if (stall_req) begin
               e_ef = 1; e_be = 1;
            end else begin
               n_pc = (m_pc + 1) & 1023; n_pcd = m_pc; e_dl = 1; e_el = 1; e_be = 1;
            end
         end else if (m_dr > 0) begin
            e_be = 1; n_dr = m_dr - 1;
         end
         if (e_be) n_pce = m_pcd;
      end
      chk("pc", pc, m_pc);
      chk("pc_decode", pc_decode, m_pcd);
      chk("pc_execute", pc_execute, m_pce);
      chk("state", state, m_st);
      chk("cycle_count", cycle_count, m_cyc);
      chk("stall_count", stall_count, m_stl);
      chk("decode_load", decode_load, e_dl);
      chk("decode_flush", decode_flush, e_df);
      chk("exec_load", exec_load, e_el);
      chk("exec_flush", exec_flush, e_ef);
      chk("back_en", back_en, e_be);
      last_be = back_en;
      @(posedge clock);
      samp.push_back(step);
      if (samp.size() > 8) void'(samp.pop_front());
      if (adv && m_st != 3 && m_cyc < 65535) m_cyc++;
      if (adv && m_st == 1 && !halt_req && !jump_req && !beq_req && stall_req && m_stl < 255) m_stl++;
      m_pc = n_pc; m_pcd = n_pcd; m_pce = n_pce; m_st = n_st; m_dr = n_dr;
      #1;
   endtask

   initial begin
      int k, p0, be_cnt;
      model_clear();
      @(posedge clock);
      #1;
      do_reset();
      run = 1'b1;

      // free run to pc=4, then a two-cycle load-use stall
      for (k = 0; k < 20 && m_pc != 4; k++) tick();
      chk("reach_pc4", pc, 4);
      stall_req = 1; tick(); tick(); stall_req = 0;
      chk("stall_hold_pc", pc, 4);
      chk("stall_count2", stall_count, 2);
      tick();
      chk("after_stall_pc", pc, 5);

      // jump at pc=7
      for (k = 0; k < 20 && m_pc != 7; k++) tick();
      chk("reach_pc7", pc, 7);
      jump_req = 1; jump_target = 10'h020; tick(); jump_req = 0;
      chk("jump_pc", pc, 10'h020);
      chk("jump_refill", state, 2);
      tick();
      chk("refill_pc", pc, 10'h021);
      chk("refill_run", state, 1);
      repeat (3) tick();

      // cycle count after five advances, then a wrapping branch
      do_reset();
      repeat (5) tick();
      chk("cyc5", cycle_count, 5);
      for (k = 0; k < 20 && m_pce != 5; k++) tick();
      chk("reach_pce5", pc_execute, 5);
      beq_req = 1; beq_offset = 10'h3fe; tick(); beq_req = 0;
      chk("beq_wrap", pc, 3);
      tick(); tick();
      jump_req = 1; jump_target = 10'h155; beq_req = 1; beq_offset = 10'h011;
      tick(); clear_reqs();
      chk("jump_over_beq", pc, 10'h155);
      repeat (2) tick();

      // pause and single-step with three held presses
      run = 0; step = 0;
      repeat (4) tick();
      p0 = m_pc;
      for (int p = 0; p < 3; p++) begin
         step = 1; repeat (5) tick();
         step = 0; repeat (5) tick();
      end
      chk("step3_pc", pc, (p0 + 3) & 1023);
      step = 1; run = 1; repeat (3) tick(); step = 0; repeat (2) tick();

      // halt at pc=9: three back_en cycles, then frozen
      do_reset();
      for (k = 0; k < 20 && m_pc != 9; k++) tick();
      chk("reach_pc9", pc, 9);
      halt_req = 1; be_cnt = 0;
      tick(); if (last_be) be_cnt++;
      halt_req = 0;
      repeat (6) begin tick(); if (last_be) be_cnt++; end
      chk("halt_be3", be_cnt, 3);
      chk("halt_pc_frozen", pc, 9);
      chk("halt_state", state, 3);
      step = 1;
      do_reset();
      tick(); tick();
      step = 0;

      // randomized traffic with occasional resets
      for (int i = 0; i < 400; i++) begin
         run         = ($urandom_range(0, 3) != 0);
         step        = $urandom_range(0, 1);
         stall_req   = ($urandom_range(0, 4) == 0);
         jump_req    = ($urandom_range(0, 9) == 0);
         beq_req     = ($urandom_range(0, 9) == 0);
         halt_req    = ($urandom_range(0, 59) == 0);
         jump_target = 10'($urandom);
         beq_offset  = 10'($urandom);
         tick();
         if ((m_st == 3 && m_dr == 0 && $urandom_range(0, 3) == 0) || $urandom_range(0, 149) == 0)
            do_reset();
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout: simulation did not reach summary");
      $fatal(1);
   end

endmodule
